// File: rtl/step_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// step_scheduler_pkg
// Shared definitions for the playback step scheduler:
//   - state_e      : transport FSM encoding (IDLE / RUN / PAUSED)
//   - TEMPO_*      : tempo_sel codes (steps/s = 16 >> tempo_sel)
//   - sub_last()   : last sub-tick value of a step for a given tempo code
// -----------------------------------------------------------------------------
package step_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2
    } state_e;

    localparam logic [1:0] TEMPO_16 = 2'd0;
    localparam logic [1:0] TEMPO_8  = 2'd1;
    localparam logic [1:0] TEMPO_4  = 2'd2;
    localparam logic [1:0] TEMPO_2  = 2'd3;

    // A step lasts (1 << tempo) ticks, so the sub counter's final value is
    // (1 << tempo) - 1. Spelled out as a table to keep it a plain 3-bit mux.
    function automatic logic [2:0] sub_last(input logic [1:0] tempo);
        logic [2:0] result;
        case (tempo)
            TEMPO_16: result = 3'd0;
            TEMPO_8:  result = 3'd1;
            TEMPO_4:  result = 3'd3;
            default:  result = 3'd7;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/step_scheduler_if.sv
// -----------------------------------------------------------------------------
// step_scheduler_if
// Step handshake between the scheduler (master) and the note player (slave).
//   step_req   : master -> slave, step_index valid, held until step_ack
//   step_index : master -> slave, pattern position being requested
//   step_ack   : slave -> master, player accepted the current step
// -----------------------------------------------------------------------------
interface step_scheduler_if #(
    parameter int STEP_W = 5
) ();
    logic              step_req;
    logic [STEP_W-1:0] step_index;
    logic              step_ack;

    modport master (
        output step_req,
        output step_index,
        input  step_ack
    );

    modport slave (
        input  step_req,
        input  step_index,
        output step_ack
    );
endinterface

// File: rtl/step_scheduler_tick_enable_gen.sv
// -----------------------------------------------------------------------------
// step_scheduler_tick_enable_gen
// Prescaler that turns the system clock into a one-cycle tick enable.
// Counts 0..DIV-1 while en_i is high; tick_o is high in the cycle where the
// count sits at DIV-1 (and en_i is high), after which the count wraps to 0.
// When en_i is low the count is frozen. clr_i forces the count back to 0.
//   clk    : system clock
//   srst   : synchronous active-high reset
//   en_i   : advance the prescaler this cycle
//   clr_i  : clear the prescaler (takes priority over en_i)
//   tick_o : one-cycle tick pulse
// -----------------------------------------------------------------------------
module step_scheduler_tick_enable_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic srst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/step_scheduler.sv
// -----------------------------------------------------------------------------
// step_scheduler
// Playback sequencer: divides CLOCK_50 into a tick enable and walks a step
// index through a pattern at 16/8/4/2 steps/s. Each step is offered to the
// note player over the req/ack interface. Play/pause/stop transport FSM.
// Ports:
//   CLOCK_50  : sole clock
//   reset     : synchronous active-high reset
//   play      : pulse, start from IDLE / resume from PAUSED
//   pause     : pulse, RUN -> PAUSED
//   stop      : pulse, any state -> IDLE
//   loop_en   : 1 wrap the pattern, 0 stop after the last step is acked
//   tempo_sel : steps/s = TICK_HZ >> tempo_sel
//   bus       : step handshake (master side): step_req, step_index, step_ack
//   tick      : one-cycle pulse at TICK_HZ while running
//   playing   : high in RUN
//   overrun   : sticky, a step came due while the previous was still pending
// -----------------------------------------------------------------------------
module step_scheduler
    import step_scheduler_pkg::*;
#(
    parameter int CLK_HZ    = 50_000_000,
    parameter int TICK_HZ   = 16,
    parameter int NUM_STEPS = 32,
    parameter int STEP_W    = 5
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                play,
    input  logic                pause,
    input  logic                stop,
    input  logic                loop_en,
    input  logic [1:0]          tempo_sel,
    step_scheduler_if.master    bus,
    output logic                tick,
    output logic                playing,
    output logic                overrun
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam logic [STEP_W-1:0] IDX_LAST = STEP_W'(NUM_STEPS - 1);

    state_e            state_q, state_d;
    logic [2:0]        sub_q, sub_d;
    logic [STEP_W-1:0] index_q, index_d;
    logic              step_req_q, step_req_d;
    logic [1:0]        tempo_q, tempo_d;
    logic              overrun_q, overrun_d;
    logic              finishing_q, finishing_d;

    logic run_en;
    logic presc_clr;
    logic step_due;
    logic last_idx;
    logic end_due;
    logic ack_fire;
    logic req_free;

    // Counters only advance in a cycle that stays in RUN, so a pause freezes
    // the prescaler at the exact count it was sampled at.
    assign run_en    = (state_q == ST_RUN) && !stop && !pause;
    assign presc_clr = (state_q == ST_IDLE) || (state_d == ST_IDLE);

    step_scheduler_tick_enable_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .clk    (CLOCK_50),
        .srst   (reset),
        .en_i   (run_en),
        .clr_i  (presc_clr),
        .tick_o (tick)
    );

    assign step_due = tick && (sub_q == sub_last(tempo_q));
    assign last_idx = (index_q == IDX_LAST);
    assign end_due  = step_due && last_idx && !loop_en;
    assign ack_fire = step_req_q && bus.step_ack;
    // The slot is free if nothing is pending or the pending step is acked now.
    assign req_free = !step_req_q || ack_fire;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // Command priority stop > pause > play; a pause that has no effect in
    // the current state still masks a coincident play.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!stop && !pause && play) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (pause) begin
                    state_d = ST_PAUSED;
                end else if ((end_due && req_free) || (finishing_q && !step_req_q)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PAUSED: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (!pause && play) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        playing = (state_q == ST_RUN);
    end

    // ---------------- step datapath ----------------
    always_comb begin
        sub_d       = sub_q;
        index_d     = index_q;
        step_req_d  = step_req_q;
        tempo_d     = tempo_q;
        overrun_d   = overrun_q;
        finishing_d = finishing_q;

        if (ack_fire) begin
            step_req_d = 1'b0;
        end

        if ((state_q == ST_IDLE) && (state_d == ST_RUN)) begin
            step_req_d = 1'b1;
            index_d    = '0;
            sub_d      = '0;
            tempo_d    = tempo_sel;
            overrun_d  = 1'b0;
        end else if (tick) begin
            if (step_due) begin
                sub_d   = '0;
                tempo_d = tempo_sel;
                if (!req_free) begin
                    // Player is late: drop this step, keep the pending one up.
                    overrun_d = 1'b1;
                    if (last_idx && !loop_en) begin
                        finishing_d = 1'b1;
                    end
                end else if (!(last_idx && !loop_en)) begin
                    index_d    = last_idx ? '0 : index_q + STEP_W'(1);
                    step_req_d = 1'b1;
                end
            end else begin
                sub_d = sub_q + 3'd1;
            end
        end

        if (state_d == ST_IDLE) begin
            step_req_d  = 1'b0;
            index_d     = '0;
            sub_d       = '0;
            finishing_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sub_q       <= '0;
            index_q     <= '0;
            step_req_q  <= 1'b0;
            tempo_q     <= TEMPO_16;
            overrun_q   <= 1'b0;
            finishing_q <= 1'b0;
        end else begin
            sub_q       <= sub_d;
            index_q     <= index_d;
            step_req_q  <= step_req_d;
            tempo_q     <= tempo_d;
            overrun_q   <= overrun_d;
            finishing_q <= finishing_d;
        end
    end

    assign bus.step_req   = step_req_q;
    assign bus.step_index = index_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_step_scheduler.sv
// -----------------------------------------------------------------------------
// tb_step_scheduler
// Directed bench for step_scheduler with CLK_HZ=160, TICK_HZ=16 (DIV=10),
// NUM_STEPS=4. Outputs are sampled 1 ns after each rising edge; inputs are
// changed at that same point so they are stable for the next edge.
// -----------------------------------------------------------------------------
module tb_step_scheduler;
    localparam int STEP_W = 2;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       play;
    logic       pause;
    logic       stop;
    logic       loop_en;
    logic [1:0] tempo_sel;
    logic       tick;
    logic       playing;
    logic       overrun;

    step_scheduler_if #(.STEP_W(STEP_W)) bus ();

    step_scheduler #(
        .CLK_HZ    (160),
        .TICK_HZ   (16),
        .NUM_STEPS (4),
        .STEP_W    (STEP_W)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .play      (play),
        .pause     (pause),
        .stop      (stop),
        .loop_en   (loop_en),
        .tempo_sel (tempo_sel),
        .bus       (bus.master),
        .tick      (tick),
        .playing   (playing),
        .overrun   (overrun)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int n_cmp    = 0;
    int n_mis    = 0;
    int cyc      = 0;
    int tick_cnt = 0;
    bit auto_ack = 1'b0;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock and sample just after the edge. With auto_ack the
    // player acks one cycle after it sees a request.
    task automatic tick_clk();
        @(posedge CLOCK_50);
        #1;
        cyc++;
        if (tick === 1'b1) tick_cnt++;
        if (auto_ack) bus.step_ack = bus.step_req;
    endtask

    task automatic pulse_cmd(input bit p, input bit pa, input bit s);
        play  = p;
        pause = pa;
        stop  = s;
        tick_clk();
        play  = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic wait_req_rise(input int limit, output int at);
        bit prev;
        at = -1;
        for (int k = 0; k < limit; k++) begin
            prev = bus.step_req;
            tick_clk();
            if (!prev && bus.step_req) begin
                at = cyc;
                $display("cycle %0d: step_req index=%0d", cyc, bus.step_index);
                break;
            end
        end
        if (at < 0) check_value("req_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int p, prev_at, at;

        reset       = 1'b1;
        play        = 1'b0;
        pause       = 1'b0;
        stop        = 1'b0;
        loop_en     = 1'b1;
        tempo_sel   = 2'd0;
        bus.step_ack = 1'b0;
        repeat (3) tick_clk();
        reset = 1'b0;
        tick_clk();

        // ---- reset state ----
        check_value("rst_req",     bus.step_req,   0);
        check_value("rst_index",   bus.step_index, 0);
        check_value("rst_tick",    tick,           0);
        check_value("rst_playing", playing,        0);
        check_value("rst_overrun", overrun,        0);

        // ---- tempo 0, looping, ack one cycle after each request ----
        auto_ack = 1'b1;
        pulse_cmd(1, 0, 0);
        $display("cycle %0d: play, step_req index=%0d", cyc, bus.step_index);
        check_value("t1_req0",     bus.step_req,   1);
        check_value("t1_idx0",     bus.step_index, 0);
        check_value("t1_playing",  playing,        1);
        tick_cnt = 0;
        prev_at  = cyc;
        for (int i = 1; i <= 4; i++) begin
            wait_req_rise(20, at);
            check_value("t1_idx",  bus.step_index, i % 4);
            check_value("t1_gap",  at - prev_at,   10);
            prev_at = at;
        end
        check_value("t1_ticks",   tick_cnt, 4);
        check_value("t1_overrun", overrun,  0);
        pulse_cmd(0, 0, 1);
        check_value("t1_stop_playing", playing, 0);

        // ---- tempo 3, no loop: four steps 80 cycles apart, then IDLE ----
        tempo_sel = 2'd3;
        loop_en   = 1'b0;
        pulse_cmd(1, 0, 0);
        $display("cycle %0d: play, step_req index=%0d", cyc, bus.step_index);
        prev_at = cyc;
        for (int i = 1; i <= 3; i++) begin
            wait_req_rise(100, at);
            check_value("t2_idx", bus.step_index, i);
            check_value("t2_gap", at - prev_at,   80);
            prev_at = at;
        end
        for (int k = 0; k < 100 && playing; k++) tick_clk();
        check_value("t2_end_gap",   cyc - prev_at,  80);
        check_value("t2_playing",   playing,        0);
        check_value("t2_req",       bus.step_req,   0);
        check_value("t2_index",     bus.step_index, 0);

        // ---- withheld ack: overrun at step_due, index held ----
        tempo_sel    = 2'd0;
        loop_en      = 1'b1;
        auto_ack     = 1'b0;
        bus.step_ack = 1'b0;
        pulse_cmd(1, 0, 0);
        $display("cycle %0d: play, step_req index=%0d (ack withheld)", cyc, bus.step_index);
        for (int k = 1; k <= 30; k++) begin
            tick_clk();
            if (k == 9)  check_value("t3_ovr_before", overrun, 0);
            if (k == 10) begin
                check_value("t3_ovr_set",  overrun,        1);
                check_value("t3_idx_held", bus.step_index, 0);
                check_value("t3_req_held", bus.step_req,   1);
            end
            if (k == 25) bus.step_ack = 1'b1;
            if (k == 26) begin
                bus.step_ack = 1'b0;
                check_value("t3_req_fall", bus.step_req, 0);
            end
            if (k == 30) begin
                $display("cycle %0d: step_req index=%0d", cyc, bus.step_index);
                check_value("t3_idx_next", bus.step_index, 1);
                check_value("t3_req_next", bus.step_req,   1);
                check_value("t3_ovr_kept", overrun,        1);
            end
        end
        pulse_cmd(0, 0, 1);
        check_value("t3_stop_req",     bus.step_req,   0);
        check_value("t3_stop_idx",     bus.step_index, 0);
        check_value("t3_stop_overrun", overrun,        1);

        // ---- pause at count 4, resume: step_due 6 cycles after play ----
        auto_ack = 1'b1;
        pulse_cmd(1, 0, 0);
        $display("cycle %0d: play, step_req index=%0d", cyc, bus.step_index);
        check_value("t4_ovr_clear", overrun, 0);
        repeat (4) tick_clk();
        pulse_cmd(0, 1, 0);
        check_value("t4_paused_playing", playing, 0);
        tick_cnt = 0;
        repeat (50) tick_clk();
        check_value("t4_paused_ticks", tick_cnt,       0);
        check_value("t4_paused_idx",   bus.step_index, 0);
        pulse_cmd(1, 0, 0);
        p = cyc;
        check_value("t4_resume_playing", playing, 1);
        wait_req_rise(20, at);
        check_value("t4_resume_gap", at - p,         6);
        check_value("t4_resume_idx", bus.step_index, 1);

        // ---- stop+pause+play together in RUN: stop wins ----
        pulse_cmd(1, 1, 1);
        check_value("t5_playing", playing,        0);
        check_value("t5_req",     bus.step_req,   0);
        check_value("t5_idx",     bus.step_index, 0);
        repeat (15) tick_clk();
        check_value("t5_still_idle", playing,      0);
        check_value("t5_still_req",  bus.step_req, 0);

        // ---- reset in the middle of RUN ----
        auto_ack     = 1'b0;
        bus.step_ack = 1'b0;
        pulse_cmd(1, 0, 0);
        repeat (12) tick_clk();
        check_value("t5_pre_rst_ovr", overrun, 1);
        reset = 1'b1;
        tick_clk();
        reset = 1'b0;
        $display("cycle %0d: reset during RUN", cyc);
        check_value("t5_rst_playing", playing,        0);
        check_value("t5_rst_req",     bus.step_req,   0);
        check_value("t5_rst_idx",     bus.step_index, 0);
        check_value("t5_rst_overrun", overrun,        0);
        check_value("t5_rst_tick",    tick,           0);

        // ---- ack coincident with step_due ----
        pulse_cmd(1, 0, 0);
        $display("cycle %0d: play, step_req index=%0d", cyc, bus.step_index);
        repeat (9) tick_clk();
        check_value("t6_req_pending", bus.step_req,   1);
        check_value("t6_idx_pending", bus.step_index, 0);
        bus.step_ack = 1'b1;
        tick_clk();
        bus.step_ack = 1'b0;
        $display("cycle %0d: step_req index=%0d (ack on step_due)", cyc, bus.step_index);
        check_value("t6_req_reissue", bus.step_req,   1);
        check_value("t6_idx_next",    bus.step_index, 1);
        check_value("t6_overrun",     overrun,        0);
        tick_clk();
        check_value("t6_req_hold",    bus.step_req,   1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
